// File: rtl/raw_pack_pkg.sv
// Shared types and constants for the RAW pixel-pair DDR packer.
package raw_pack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOL,
    LINE
  } state_t;

  localparam int PIX_PER_WORD        = 4;
  localparam int DEF_PIX_PER_LINE    = 1280;
  localparam int DEF_LINES_PER_FRAME = 720;
  localparam int DEF_LCNT_W          = 10;

  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [63:0] data;
  } pack_entry_t;

  localparam int ENTRY_W = $bits(pack_entry_t);

  // One pixel pair as it sits inside the packed word: camera 2 in the upper byte.
  function automatic logic [15:0] pix_pair(input logic [7:0] raw1, input logic [7:0] raw2);
    return {raw2, raw1};
  endfunction

endpackage

// File: rtl/raw_pack_fifo2.sv
// Two-entry FIFO between the word assembler and the Avalon-ST source.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module raw_pack_fifo2
  import raw_pack_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic               drop
);

  logic [ENTRY_W-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/raw_pair_ddr_packer.sv
// Packs four RAW_1/RAW_2 pixel pairs into one 64-bit Avalon-ST word with frame framing and error flags.
// Optional test pattern source is compiled in with `define PACKER_TEST_PATTERN_EN.
module raw_pair_ddr_packer
  import raw_pack_pkg::*;
#(
  parameter int PIX_PER_LINE    = DEF_PIX_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int LCNT_W          = DEF_LCNT_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              valid_RAW,
  input  logic [7:0]        RAW_1,
  input  logic [7:0]        RAW_2,
  input  logic              SOF,
  input  logic              EOF,
  input  logic              start_frame,
  input  logic              test_mode,
  output logic [63:0]       data_ddr,
  output logic              valid_data_ddr,
  input  logic              ready_ddr,
  output logic              sop_ddr,
  output logic              eop_ddr,
  output logic [LCNT_W-1:0] line_cnt,
  output logic              frame_done,
  output logic              err_align,
  output logic              err_len,
  output logic              err_ovf
);

  localparam int PCNT_W = $clog2(PIX_PER_LINE) + 1;

  state_t             state, state_nx;
  logic [PCNT_W-1:0]  pix_cnt, pix_nx, idx;
  logic [LCNT_W-1:0]  line_nx;
  logic [2:0][15:0]   slots;
  logic [15:0]        pix;
  logic [7:0]         pix_a, pix_b;

  logic               sof_hit, take, eof_hit, good_eof, last_line;
  logic               wr_slot, word_done, push_word, push_eop;
  logic               set_align, set_len, clr_err;

  logic               pend_vld;
  pack_entry_t        pend;
  pack_entry_t        head;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_empty, fifo_drop, pop;

  // A SOF restarts the line, so the pixel index is 0 whatever pix_cnt holds.
  assign sof_hit   = valid_RAW & SOF & (state != IDLE);
  assign take      = valid_RAW & (sof_hit | (state == LINE));
  assign idx       = sof_hit ? '0 : pix_cnt;
  assign eof_hit   = take & EOF;
  assign good_eof  = (idx == PCNT_W'(PIX_PER_LINE - 1));
  assign last_line = (line_cnt == LCNT_W'(LINES_PER_FRAME - 1));

`ifdef PACKER_TEST_PATTERN_EN
  assign pix_a = test_mode ? 8'(idx) : RAW_1;
  assign pix_b = test_mode ? 8'(line_cnt) : RAW_2;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_a = RAW_1;
  assign pix_b = RAW_2;
`endif

  assign pix = pix_pair(pix_a, pix_b);

  always_comb begin
    state_nx  = state;
    pix_nx    = pix_cnt;
    line_nx   = line_cnt;
    set_align = 1'b0;
    set_len   = 1'b0;
    clr_err   = 1'b0;
    wr_slot   = 1'b0;
    word_done = 1'b0;
    push_word = 1'b0;
    push_eop  = 1'b0;
    if (start_frame) begin
      // Restart from any state; errors clear only on a clean start from IDLE.
      clr_err  = (state == IDLE);
      line_nx  = '0;
      pix_nx   = '0;
      state_nx = WAIT_SOL;
    end else if (take) begin
      set_align = sof_hit & (state == LINE);
      wr_slot   = 1'b1;
      word_done = (idx[1:0] == 2'(PIX_PER_WORD - 1));
      if (eof_hit) begin
        set_len   = ~good_eof;
        push_word = word_done & good_eof;
        push_eop  = last_line;
        pix_nx    = '0;
        if (last_line) begin
          state_nx = IDLE;
        end else begin
          line_nx  = line_cnt + 1'b1;
          state_nx = WAIT_SOL;
        end
      end else begin
        push_word = word_done;
        pix_nx    = idx + 1'b1;
        state_nx  = LINE;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      slots      <= '0;
      pend_vld   <= 1'b0;
      pend       <= '0;
      err_align  <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state    <= state_nx;
      pix_cnt  <= pix_nx;
      line_cnt <= line_nx;
      if (wr_slot) begin
        case (idx[1:0])
          2'd0:    slots[0] <= pix;
          2'd1:    slots[1] <= pix;
          2'd2:    slots[2] <= pix;
          default: ;
        endcase
      end
      // The 4th pixel bypasses the slots straight into the staging word.
      pend_vld <= push_word;
      if (push_word) begin
        pend.data <= {pix, slots[2], slots[1], slots[0]};
        pend.sop  <= (line_cnt == '0) && (idx == PCNT_W'(PIX_PER_WORD - 1));
        pend.eop  <= push_eop;
      end
      err_align  <= (err_align & ~clr_err) | set_align;
      err_len    <= (err_len & ~clr_err) | set_len;
      err_ovf    <= (err_ovf & ~clr_err) | fifo_drop;
      frame_done <= pop & head.eop;
    end
  end

  raw_pack_fifo2 u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (pend_vld),
    .din   (pend),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign head           = fifo_dout;
  assign valid_data_ddr = ~fifo_empty;
  assign pop            = valid_data_ddr & ready_ddr;
  assign data_ddr       = head.data;
  assign sop_ddr        = head.sop & ~fifo_empty;
  assign eop_ddr        = head.eop & ~fifo_empty;

endmodule

// File: tb/tb_raw_pair_ddr_packer.sv
// Scoreboard bench for raw_pair_ddr_packer: directed framing cases plus randomized frames and sink stalls.
module tb_raw_pair_ddr_packer;
  localparam int PPL = 8;
  localparam int LPF = 2;
  localparam int LW  = 4;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          valid_RAW = 1'b0, SOF = 1'b0, EOF = 1'b0, start_frame = 1'b0, test_mode = 1'b0;
  logic          ready_ddr = 1'b0;
  logic [7:0]    RAW_1 = '0, RAW_2 = '0;
  logic [63:0]   data_ddr;
  logic          valid_data_ddr, sop_ddr, eop_ddr, frame_done, err_align, err_len, err_ovf;
  logic [LW-1:0] line_cnt;

  raw_pair_ddr_packer #(.PIX_PER_LINE(PPL), .LINES_PER_FRAME(LPF), .LCNT_W(LW)) dut (
    .clk_sys(clk_sys), .reset(reset), .valid_RAW(valid_RAW), .RAW_1(RAW_1), .RAW_2(RAW_2),
    .SOF(SOF), .EOF(EOF), .start_frame(start_frame), .test_mode(test_mode),
    .data_ddr(data_ddr), .valid_data_ddr(valid_data_ddr), .ready_ddr(ready_ddr),
    .sop_ddr(sop_ddr), .eop_ddr(eop_ddr), .line_cnt(line_cnt), .frame_done(frame_done),
    .err_align(err_align), .err_len(err_len), .err_ovf(err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [63:0] data;
  } wrd_t;

  wrd_t        exp_q[$];
  int          checks = 0, errors = 0;
  int          mocc = 0, midx = 0, mline = 0;
  bit          mact = 0, minl = 0, m_al = 0, m_ln = 0, m_ov = 0;
  logic [15:0] cur [4];
  bit          pend_v = 0;
  wrd_t        pend;
  int          rdy_mode = 0, fd_cnt = 0, m_fd = 0;
  bit          cap_first = 0, first_sop = 0;
  logic [63:0] first_word = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: pixels are gathered per line; every 4th pixel yields a word that
  // reaches a 2-deep buffer one cycle later, where it is either kept or lost.
  always @(posedge clk_sys) begin
    bit          was_v;
    wrd_t        was;
    int          k;
    logic [7:0]  a, b;
    was_v  = pend_v;
    was    = pend;
    pend_v = 0;
    if (reset) begin
      mocc = 0; exp_q.delete(); mact = 0; minl = 0; midx = 0; mline = 0;
      m_al = 0; m_ln = 0; m_ov = 0;
    end else begin
      if (start_frame) begin
        if (!mact) begin m_al = 0; m_ln = 0; m_ov = 0; end
        mact = 1; minl = 0; mline = 0;
      end else if (mact && valid_RAW && (SOF || minl)) begin
        if (SOF) begin
          if (minl) m_al = 1;
          minl = 1; midx = 0;
        end
        k = midx;
        a = RAW_1;
        b = RAW_2;
`ifdef PACKER_TEST_PATTERN_EN
        if (test_mode) begin a = 8'(k); b = 8'(mline); end
`endif
        cur[k % 4] = {b, a};
        if (EOF) begin
          if (k != PPL - 1) m_ln = 1;
          else begin
            pend_v = 1;
            pend.data = {cur[3], cur[2], cur[1], cur[0]};
            pend.sop = (mline == 0) && (k == 3);
            pend.eop = (mline == LPF - 1);
          end
          minl = 0;
          if (mline == LPF - 1) mact = 0; else mline++;
        end else begin
          if (k % 4 == 3) begin
            pend_v = 1;
            pend.data = {cur[3], cur[2], cur[1], cur[0]};
            pend.sop = (mline == 0) && (k == 3);
            pend.eop = 0;
          end
          midx = k + 1;
        end
      end
      if (mocc > 0 && ready_ddr) mocc--;
      if (was_v) begin
        if (mocc < 2) begin mocc++; exp_q.push_back(was); end
        else m_ov = 1;
      end
    end
  end

  // Monitor: the presented word must match the scoreboard head for as long as it is shown.
  always @(negedge clk_sys) begin
    wrd_t e;
    if (!reset) begin
      chk("valid", valid_data_ddr, mocc > 0);
      chk("line_cnt", line_cnt, mline);
      if (frame_done) fd_cnt++;
      if (valid_data_ddr) begin
        chk("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("data", data_ddr, e.data);
          chk("sop", sop_ddr, e.sop);
          chk("eop", eop_ddr, e.eop);
          if (ready_ddr) begin
            void'(exp_q.pop_front());
            if (e.eop) m_fd++;
            if (cap_first) begin first_word = data_ddr; first_sop = sop_ddr; cap_first = 0; end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_sys); #1;
      case (rdy_mode)
        0:       ready_ddr = 1'b1;
        1:       ready_ddr = ($urandom_range(0, 3) != 0);
        default: ready_ddr = 1'b0;
      endcase
    end
  end

  task automatic cyc(input bit v, input bit s, input bit e, input logic [7:0] a, input logic [7:0] b);
    valid_RAW = v; SOF = s; EOF = e; RAW_1 = a; RAW_2 = b;
    test_mode = 1'($urandom_range(0, 1));
    @(posedge clk_sys); #1;
    valid_RAW = 0; SOF = 0; EOF = 0; start_frame = 0;
  endtask

  task automatic sf();
    start_frame = 1;
    cyc(0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic send_line(input int n, input int sof2, input bit with_eof, input bit rnd, input int gap);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a, b;
      a = rnd ? 8'($urandom) : 8'(i);
      b = rnd ? 8'($urandom) : 8'(8'h80 + i);
      cyc(1, (i == 0) || (i == sof2), with_eof && (i == n - 1), a, b);
      if (gap > 0) repeat ($urandom_range(0, gap)) cyc(0, 0, 0, 8'h00, 8'h00);
    end
  endtask

  task automatic drain(input string tag);
    rdy_mode = 0;
    for (int i = 0; i < 40 && valid_data_ddr; i++) cyc(0, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc(0, 0, 0, 8'h00, 8'h00);
    chk({tag, "_drained"}, valid_data_ddr, 0);
    chk({tag, "_frame_done_cnt"}, fd_cnt, m_fd);
    chk({tag, "_err_align"}, err_align, m_al);
    chk({tag, "_err_len"}, err_len, m_ln);
    chk({tag, "_err_ovf"}, err_ovf, m_ov);
  endtask

  initial begin
    int fd0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_valid", valid_data_ddr, 0);
    chk("rst_sop", sop_ddr, 0);
    chk("rst_eop", eop_ddr, 0);
    chk("rst_data", data_ddr, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_errs", {err_align, err_len, err_ovf}, 0);
    reset = 0;
    cyc(0, 0, 0, 8'h00, 8'h00);

    // Nominal frame
    fd0 = fd_cnt; cap_first = 1;
    sf();
    send_line(PPL, -1, 1, 0, 0);
    cyc(0, 0, 0, 8'h00, 8'h00);
    send_line(PPL, -1, 1, 0, 0);
    drain("nominal");
    chk("nominal_word0", first_word, 64'h8303_8202_8101_8000);
    chk("nominal_word0_sop", first_sop, 1);
    chk("nominal_frame_done", fd_cnt - fd0, 1);
    chk("nominal_no_errs", {err_align, err_len, err_ovf}, 0);

    // Backpressure: sink stalls across two full lines
    rdy_mode = 2;
    sf();
    send_line(PPL, -1, 1, 0, 0);
    send_line(PPL, -1, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 8'h00, 8'h00);
    chk("bp_err_ovf", err_ovf, 1);
    drain("backpressure");

    // Misalignment: SOF again at pixel 5
    sf();
    send_line(PPL + 5, 5, 1, 0, 0);
    send_line(PPL, -1, 1, 0, 0);
    drain("misalign");
    chk("misalign_err_align", err_align, 1);

    // Short line
    sf();
    send_line(6, -1, 1, 0, 0);
    cyc(0, 0, 0, 8'h00, 8'h00);
    chk("short_line_cnt", line_cnt, 1);
    send_line(PPL, -1, 1, 0, 0);
    drain("short");
    chk("short_err_len", err_len, 1);

    // Abort mid line 1
    sf();
    send_line(PPL, -1, 1, 0, 0);
    send_line(5, -1, 0, 0, 0);
    drain("abort_pre");
    cap_first = 1;
    sf();
    chk("abort_line_cnt", line_cnt, 0);
    send_line(PPL, -1, 1, 1, 1);
    send_line(PPL, -1, 1, 1, 1);
    drain("abort");
    chk("abort_new_sop", first_sop, 1);

    // Reset mid-frame with a word held in the buffer
    rdy_mode = 2;
    sf();
    send_line(5, -1, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 8'h00);
    chk("pre_rst_valid", valid_data_ddr, 1);
    reset = 1;
    cyc(0, 0, 0, 8'h00, 8'h00);
    reset = 0;
    chk("midrst_valid", valid_data_ddr, 0);
    chk("midrst_flags", {sop_ddr, eop_ddr, frame_done, err_align, err_len, err_ovf}, 0);
    chk("midrst_line_cnt", line_cnt, 0);
    rdy_mode = 0;
    send_line(PPL, -1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 8'h00, 8'h00);
    chk("midrst_idle_no_word", valid_data_ddr, 0);

    // Randomized frames with random stalls, short lines, misaligned SOF and aborts
    for (int f = 0; f < 30; f++) begin
      rdy_mode = 1;
      sf();
      for (int l = 0; l < LPF; l++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 8)       send_line($urandom_range(1, PPL - 1), -1, 1, 1, 2);
        else if (r < 16) send_line(PPL + 5, $urandom_range(1, 5), 1, 1, 2);
        else if (r < 21) begin send_line($urandom_range(1, PPL - 1), -1, 0, 1, 1); break; end
        else             send_line(PPL, -1, 1, 1, $urandom_range(0, 2));
      end
      if (f % 5 == 4) drain("random");
    end
    drain("random_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/raw_pair_ddr_packer.md
Name: raw_pair_ddr_packer

Overview:
- Sits directly downstream of the dual-camera DVP→clk_sys FIFO stage.
- Consumes the aligned 8-bit RAW pixel pair (RAW_1/RAW_2) with valid, line SOF/EOF markers and the frame start pulse.
- Packs 4 pixel pairs into one 64-bit word and presents it as an Avalon-ST source toward the DDR writer.
- Absorbs short sink stalls in a 2-entry buffer; tracks line/frame position; reports alignment, length and overflow errors.

Parameters:
- PIX_PER_LINE, 1280, pixels per line; must be a multiple of 4.
- LINES_PER_FRAME, 720, lines per frame.
- LCNT_W, 10, width of the line counter; must satisfy 2^LCNT_W > LINES_PER_FRAME.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- valid_RAW  in  1  pixel pair valid; no backpressure upstream.
- RAW_1  in  8  camera 1 pixel.
- RAW_2  in  8  camera 2 pixel.
- SOF  in  1  first pixel of a line; qualified by valid_RAW.
- EOF  in  1  last pixel of a line; qualified by valid_RAW.
- start_frame  in  1  single-cycle frame start pulse.
- test_mode  in  1  selects the test pattern; used only with PACKER_TEST_PATTERN_EN.
- data_ddr  out  64  packed word.
- valid_data_ddr  out  1  Avalon-ST valid.
- ready_ddr  in  1  Avalon-ST ready from the sink.
- sop_ddr  out  1  first word of a frame.
- eop_ddr  out  1  last word of a frame.
- line_cnt  out  LCNT_W  current line index.
- frame_done  out  1  1-cycle pulse when a frame's eop word is accepted by the sink.
- err_align  out  1  sticky; SOF arrived mid-line.
- err_len  out  1  sticky; EOF arrived at the wrong pixel count.
- err_ovf  out  1  sticky; a completed word was dropped because the buffer was full.

Behaviour:
- Clock and reset: single clock clk_sys. Reset is synchronous and active-high, port name reset.
- Reset values: all outputs 0. FSM in IDLE. All counters 0. Buffer empty.
- Word layout: pixel k (k = 0..3, arrival order) occupies data_ddr[16k+15:16k] = {RAW_2, RAW_1}.
- FSM states and transitions:
  - IDLE: wait for start_frame. On start_frame: clear sticky errors, line_cnt=0, go to WAIT_SOL.
  - WAIT_SOL: pixels without SOF are ignored. valid_RAW & SOF → pix_cnt=1, store pixel 0, go to LINE.
  - LINE: each valid pixel is stored at slot pix_cnt[1:0], then pix_cnt increments.
  - When slot 3 is written, the word is pushed into the buffer the next cycle.
  - On valid EOF: if pix_cnt != PIX_PER_LINE-1, set err_len and discard the partial word.
  - After EOF: if line_cnt == LINES_PER_FRAME-1, the pushed word carries eop, line_cnt is held, and the FSM goes to IDLE. Otherwise line_cnt increments and the FSM goes to WAIT_SOL.
- sop_ddr: carried on the first word of line 0.
- Boundary and error conditions:
  - SOF while in LINE: set err_align, drop the partial word, restart at pixel 0 with the current pixel.
  - start_frame outside IDLE: abort the current frame, drop the partial word, line_cnt=0, go to WAIT_SOL. Sticky errors are not cleared.
  - SOF and EOF in the same valid cycle: treated as SOF, then err_len.
- Buffer:
  - 2-entry FIFO holding {eop, sop, data}.
  - valid_data_ddr = !empty. A pop occurs on valid & ready.
  - Push and pop in the same cycle are allowed when the buffer is full.
  - Push while full without a pop: the word is dropped and err_ovf is set.
  - Word flags: eop is carried only if that word is accepted; sop likewise.
- Latency: 4th pixel at cycle N → valid_data_ddr at N+2 when the buffer is empty. Output registers hold steady while valid & !ready.
- Throughput: 1 word per 4 valid pixels. Sustained with ready ≥ 25% duty.

Optional Feature:
- Macro: PACKER_TEST_PATTERN_EN.
- Defined: when test_mode=1, RAW_1 is replaced by pix_cnt[7:0] and RAW_2 by line_cnt[7:0] before packing. Framing and markers are unchanged.
- Undefined: test_mode is ignored and the pattern logic is absent.

Decomposition:
- Package raw_pack_pkg:
  - state enum {IDLE, WAIT_SOL, LINE}.
  - PIX_PER_WORD=4.
  - Buffer entry struct {eop, sop, data[63:0]}.
  - Default line/frame constants.
- One sub-module: raw_pack_fifo2, the 2-entry FIFO with full/empty and a synchronous active-high reset.

Test Plan:
- Nominal frame: PIX_PER_LINE=8, LINES_PER_FRAME=2, start_frame, 2 lines of 8 pixels with RAW_1=i, RAW_2=0x80+i, ready=1.
  - → 4 words. Word0 = 0x8303_8202_8101_8000 with sop=1. Word3 eop=1.
  - → frame_done pulses once. No errors.
- Backpressure: ready=0 for 12 cycles mid-line with valid every cycle.
  - → first 2 words held stable, 3rd dropped, err_ovf=1.
  - → after ready=1, the 2 held words are delivered in order.
- Misalignment: SOF at pixel 5 of an 8-pixel line.
  - → err_align=1, partial word dropped, next word starts at the new SOF pixel.
- Short line: EOF at pixel 6 of 8.
  - → err_len=1, no partial word emitted, line_cnt advances.
- Abort: start_frame mid-line 1.
  - → line_cnt=0, the next SOF word carries sop=1, no eop for the aborted frame.
- Reset mid-frame: reset for 1 cycle with 1 word buffered.
  - → valid_data_ddr=0 and all flags 0 on the next cycle; the FSM waits for start_frame.
